// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared fetch-path constants and the queued fetch entry type.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

  localparam int unsigned IFQ_DEPTH        = 2;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Sequential PC; wraps naturally modulo 2^32.
  function automatic logic [31:0] pc_next(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ifq_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ifq_fifo
// Description : Instruction queue; registered, no bypass, flushable, head zeroed when empty.
// Revision    : 1.0 - initial release
// ============================================================================
module ifq_fifo
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH = IFQ_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  fetch_entry_t               i_data,
  input  logic                       i_pop,
  input  logic                       i_flush,
  output fetch_entry_t               o_head,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int unsigned      PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned      CNT_W   = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] c_LAST  = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] c_DEPTH = CNT_W'(DEPTH);

  fetch_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == c_DEPTH);
  assign o_count = r_count;
  assign w_pop   = i_pop && !o_empty;
  assign o_head  = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= (r_wr_ptr == c_LAST) ? '0 : r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= (r_rd_ptr == c_LAST) ? '0 : r_rd_ptr + PTR_W'(1);
      case ({i_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
  end

  // A simultaneous pop frees the slot, so only a push without pop may not hit a full queue.
  always_ff @(posedge clk) begin
    if (!rst && !i_flush) a_no_overflow: assert (!(i_push && !w_pop && o_full));
  end

endmodule
`default_nettype wire

// File: rtl/ifetch.sv
`default_nettype none
// ============================================================================
// Module      : ifetch
// Description : In-order instruction fetch with bounded in-flight requests and redirect drop.
// Revision    : 1.0 - initial release
// ============================================================================
module ifetch
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned DEPTH    = IFQ_DEPTH
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  input  logic        instr_ready_i
);

  localparam int unsigned      CNT_W   = $clog2(DEPTH + 1);
  localparam logic [CNT_W:0]   c_DEPTH = (CNT_W + 1)'(DEPTH);

  logic [31:0]      r_fetch_pc;
  logic [31:0]      r_resp_pc;
  logic [CNT_W-1:0] r_outstanding;
  logic [CNT_W-1:0] r_drop;

  logic [CNT_W-1:0] w_q_count;
  logic [CNT_W:0]   w_inflight;
  logic [CNT_W-1:0] w_gnt_inc;
  logic [CNT_W-1:0] w_rsp_dec;
  logic [31:0]      w_target;
  logic             w_grant;
  logic             w_push;
  logic             w_pop;
  logic             w_q_empty;
  logic             w_q_full;
  fetch_entry_t     w_push_entry;
  fetch_entry_t     w_head;

  assign w_target     = {redirect_pc_i[31:2], 2'b00};
  assign w_inflight   = {1'b0, r_outstanding} + {1'b0, w_q_count};
  assign imem_req_o   = !reset && !redirect_i && !w_q_full && (w_inflight < c_DEPTH);
  assign imem_addr_o  = r_fetch_pc;
  assign w_grant      = imem_req_o && imem_gnt_i;
  assign w_gnt_inc    = CNT_W'(w_grant);
  assign w_rsp_dec    = CNT_W'(imem_rvalid_i && (r_outstanding != '0));
  assign w_push       = imem_rvalid_i && !redirect_i && (r_drop == '0);
  assign w_pop        = instr_valid_o && instr_ready_i && !redirect_i;
  assign w_push_entry = '{pc: r_resp_pc, instr: imem_rdata_i};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_outstanding <= '0;
      r_drop        <= '0;
    end else if (redirect_i) begin
      // Every request still in flight after this cycle belongs to the old path.
      r_fetch_pc    <= w_target;
      r_resp_pc     <= w_target;
      r_outstanding <= r_outstanding - w_rsp_dec;
      r_drop        <= r_outstanding - w_rsp_dec;
    end else begin
      if (w_grant) r_fetch_pc <= pc_next(r_fetch_pc);
      if (w_push)  r_resp_pc  <= pc_next(r_resp_pc);
      if (imem_rvalid_i && (r_drop != '0)) r_drop <= r_drop - CNT_W'(1);
      r_outstanding <= r_outstanding + w_gnt_inc - w_rsp_dec;
    end
  end

  ifq_fifo #(
    .DEPTH (DEPTH)
  ) u_ifq (
    .clk     (clk),
    .rst     (reset),
    .i_push  (w_push),
    .i_data  (w_push_entry),
    .i_pop   (w_pop),
    .i_flush (redirect_i),
    .o_head  (w_head),
    .o_full  (w_q_full),
    .o_empty (w_q_empty),
    .o_count (w_q_count)
  );

  assign instr_valid_o = !w_q_empty;
  assign instr_o       = w_head.instr;
  assign pc_o          = w_head.pc;

endmodule
`default_nettype wire
